// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT front end: frame length, default
// sample width and the frame loader state encoding.
package fft16_pkg;

    localparam int FFT16_LEN   = 16;
    localparam int FFT16_N     = 18;
    localparam int FFT16_IDX_W = 4;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/fft16_sample_bank.sv
// One 16-entry complex sample store: indexed write port, whole frame visible
// as flat real/imaginary buses. Contents are deliberately not reset.
module fft16_sample_bank
    import fft16_pkg::*;
#(
    parameter int N = FFT16_N
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [FFT16_IDX_W-1:0]   wr_idx,
    input  logic [N-1:0]             wr_re,
    input  logic [N-1:0]             wr_im,
    output logic [FFT16_LEN*N-1:0]   rd_re,
    output logic [FFT16_LEN*N-1:0]   rd_im
);

    logic [N-1:0] mem_re [FFT16_LEN];
    logic [N-1:0] mem_im [FFT16_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_idx] <= wr_re;
            mem_im[wr_idx] <= wr_im;
        end
    end

    for (genvar k = 0; k < FFT16_LEN; k++) begin : g_rd
        assign rd_re[k*N +: N] = mem_re[k];
        assign rd_im[k*N +: N] = mem_im[k];
    end

endmodule

// File: rtl/fft16_frame_loader.sv
// Collects 16 streamed complex samples into a frame and runs the level-sensitive
// start/done handshake of fft_16point. FFT16_LOADER_PINGPONG_EN adds a second bank.
module fft16_frame_loader
    import fft16_pkg::*;
#(
    parameter int N = FFT16_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [N-1:0]      s_re,
    input  logic signed [N-1:0]      s_im,
    output logic [FFT16_LEN*N-1:0]   frame_re,
    output logic [FFT16_LEN*N-1:0]   frame_im,
    output logic                     fft_start,
    input  logic                     fft_done,
    output logic                     frame_done,
    output logic [15:0]              frame_cnt
);

    loader_state_t              state;
    loader_state_t              state_next;
    logic [FFT16_IDX_W-1:0]     wr_idx;
    logic                       accept;
    logic                       last_sample;

    assign accept      = s_valid && s_ready;
    assign last_sample = accept && (wr_idx == 4'd15);

`ifdef FFT16_LOADER_PINGPONG_EN
    // bank names the running bank in RUN/GAP and the filling bank in FILL
    logic                       bank;
    logic                       other_full;
    logic                       wr_bank;
    logic [FFT16_LEN*N-1:0]     rd_re0, rd_im0, rd_re1, rd_im1;

    assign wr_bank = (state == FILL) ? bank : ~bank;

    fft16_sample_bank #(.N(N)) u_bank0 (
        .clk    (clk),
        .wr_en  (accept && !wr_bank),
        .wr_idx (wr_idx),
        .wr_re  (s_re),
        .wr_im  (s_im),
        .rd_re  (rd_re0),
        .rd_im  (rd_im0)
    );

    fft16_sample_bank #(.N(N)) u_bank1 (
        .clk    (clk),
        .wr_en  (accept && wr_bank),
        .wr_idx (wr_idx),
        .wr_re  (s_re),
        .wr_im  (s_im),
        .rd_re  (rd_re1),
        .rd_im  (rd_im1)
    );

    assign frame_re = bank ? rd_re1 : rd_re0;
    assign frame_im = bank ? rd_im1 : rd_im0;
    assign s_ready  = (state == FILL) || !other_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank       <= 1'b0;
            other_full <= 1'b0;
        end else if (state == GAP) begin
            bank       <= ~bank;
            other_full <= 1'b0;
        end else if (last_sample && state != FILL) begin
            other_full <= 1'b1;
        end
    end
`else
    fft16_sample_bank #(.N(N)) u_bank (
        .clk    (clk),
        .wr_en  (accept),
        .wr_idx (wr_idx),
        .wr_re  (s_re),
        .wr_im  (s_im),
        .rd_re  (frame_re),
        .rd_im  (frame_im)
    );

    assign s_ready = (state == FILL);
`endif

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (last_sample) state_next = RUN;
            RUN:  if (fft_done)    state_next = GAP;
            GAP: begin
                state_next = FILL;
`ifdef FFT16_LOADER_PINGPONG_EN
                if (other_full || last_sample) state_next = RUN;
`endif
            end
            default: state_next = FILL;
        endcase
    end

    // start/done outputs are registered copies of the next state, so start
    // drops on the same edge that leaves RUN (including the reset edge)
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_idx     <= '0;
            fft_start  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_next;
            fft_start  <= (state_next == RUN);
            frame_done <= (state_next == GAP);
            if (accept)
                wr_idx <= wr_idx + 4'd1;
            if (state == RUN && state_next == GAP)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft16_frame_loader.sv
// Self-checking bench for fft16_frame_loader: directed ramp/spurious/reset
// scenarios plus randomized streams against a frame-queue reference model.
module tb_fft16_frame_loader;
    import fft16_pkg::*;

    localparam int N  = 18;
    localparam int FW = FFT16_LEN * N;
`ifdef FFT16_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   s_valid;
    logic                   s_ready;
    logic signed [N-1:0]    s_re;
    logic signed [N-1:0]    s_im;
    logic [FW-1:0]          frame_re;
    logic [FW-1:0]          frame_im;
    logic                   fft_start;
    logic                   fft_done;
    logic                   frame_done;
    logic [15:0]            frame_cnt;

    int  checks;
    int  passed;
    int  cycles_high;
    int  fft_lat;
    bit  done_force;
    bit  last_acc;
    bit  last_done;

    fft16_frame_loader #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .frame_re   (frame_re),
        .frame_im   (frame_im),
        .fft_start  (fft_start),
        .fft_done   (fft_done),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step; also plays the FFT, raising done after fft_lat start cycles
    task automatic tick();
        last_acc  = s_valid && s_ready;
        last_done = fft_done;
        @(posedge clk);
        #1;
        if (fft_start) cycles_high++;
        else           cycles_high = 0;
        fft_done = done_force || (fft_start && cycles_high >= fft_lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0;
        done_force = 1'b0; fft_done = 1'b0; fft_lat = 40; cycles_high = 0;
        tick(); tick();
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL reset s_ready: got %b expected 1", s_ready); else passed++;
        checks++; if (fft_start !== 1'b0) $display("[TB] FAIL reset fft_start: got %b expected 0", fft_start); else passed++;
        checks++; if (frame_done !== 1'b0) $display("[TB] FAIL reset frame_done: got %b expected 0", frame_done); else passed++;
        checks++; if (frame_cnt !== 16'd0) $display("[TB] FAIL reset frame_cnt: got %0d expected 0", frame_cnt); else passed++;
        checks++; if (dut.wr_idx !== 4'd0) $display("[TB] FAIL reset wr_idx: got %0d expected 0", dut.wr_idx); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        logic [FW-1:0] exp_re, exp_im;
        int  acc_n, high;
        bit  got_done;
        fft_lat = 40;
        acc_n = 0;
        for (int c = 0; c < 40 && acc_n < 16; c++) begin
            s_valid = 1'b1;
            s_re = N'(acc_n);
            s_im = N'(-acc_n);
            exp_re[acc_n*N +: N] = N'(acc_n);
            exp_im[acc_n*N +: N] = N'(-acc_n);
            tick();
            if (last_acc) acc_n++;
        end
        s_valid = 1'b0;
        checks++; if (acc_n !== 16) $display("[TB] FAIL ramp accepts: got %0d expected 16", acc_n); else passed++;
        checks++; if (fft_start !== 1'b1) $display("[TB] FAIL ramp start after 16th: got %b expected 1", fft_start); else passed++;
        high = 1;
        got_done = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            tick();
            if (fft_start) high++;
            if (frame_done) got_done = 1'b1;
        end
        checks++; if (got_done !== 1'b1) $display("[TB] FAIL ramp frame_done timeout: got %b expected 1", got_done); else passed++;
        checks++; if (high !== fft_lat) $display("[TB] FAIL ramp start width: got %0d expected %0d", high, fft_lat); else passed++;
        checks++; if (fft_start !== 1'b0) $display("[TB] FAIL ramp start in gap: got %b expected 0", fft_start); else passed++;
        checks++; if (frame_re !== exp_re) $display("[TB] FAIL ramp frame_re: got %h expected %h", frame_re, exp_re); else passed++;
        checks++; if (frame_im !== exp_im) $display("[TB] FAIL ramp frame_im: got %h expected %h", frame_im, exp_im); else passed++;
        checks++; if (frame_cnt !== 16'd1) $display("[TB] FAIL ramp frame_cnt: got %0d expected 1", frame_cnt); else passed++;
        tick();
        checks++; if (frame_done !== 1'b0) $display("[TB] FAIL ramp done pulse width: got %b expected 0", frame_done); else passed++;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL ramp back to fill: got %b expected 1", s_ready); else passed++;
    endtask

    task automatic test_spurious_done();
        int acc_n;
        acc_n = 0;
        for (int c = 0; c < 20 && acc_n < 5; c++) begin
            s_valid = 1'b1; s_re = N'($urandom); s_im = N'($urandom);
            tick();
            if (last_acc) acc_n++;
        end
        s_valid = 1'b0;
        done_force = 1'b1; fft_done = 1'b1;
        tick(); tick(); tick();
        checks++; if (fft_start !== 1'b0) $display("[TB] FAIL spurious fft_start: got %b expected 0", fft_start); else passed++;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL spurious s_ready: got %b expected 1", s_ready); else passed++;
        checks++; if (frame_done !== 1'b0) $display("[TB] FAIL spurious frame_done: got %b expected 0", frame_done); else passed++;
        checks++; if (frame_cnt !== 16'd1) $display("[TB] FAIL spurious frame_cnt: got %0d expected 1", frame_cnt); else passed++;
        checks++; if (dut.wr_idx !== 4'd5) $display("[TB] FAIL spurious wr_idx: got %0d expected 5", dut.wr_idx); else passed++;
        done_force = 1'b0; fft_done = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int acc_n;
        fft_lat = 1000;
        acc_n = 5;
        for (int c = 0; c < 40 && acc_n < 16; c++) begin
            s_valid = 1'b1; s_re = N'($urandom); s_im = N'($urandom);
            tick();
            if (last_acc) acc_n++;
        end
        s_valid = 1'b0;
        checks++; if (fft_start !== 1'b1) $display("[TB] FAIL midrun start: got %b expected 1", fft_start); else passed++;
        for (int c = 0; c < 9; c++) tick();
        checks++; if (fft_start !== 1'b1) $display("[TB] FAIL midrun still running: got %b expected 1", fft_start); else passed++;
        rst = 1'b1;
        tick();
        checks++; if (fft_start !== 1'b0) $display("[TB] FAIL midrun reset fft_start: got %b expected 0", fft_start); else passed++;
        checks++; if (dut.wr_idx !== 4'd0) $display("[TB] FAIL midrun reset wr_idx: got %0d expected 0", dut.wr_idx); else passed++;
        checks++; if (frame_cnt !== 16'd0) $display("[TB] FAIL midrun reset frame_cnt: got %0d expected 0", frame_cnt); else passed++;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL midrun reset s_ready: got %b expected 1", s_ready); else passed++;
        rst = 1'b0;
        tick();
    endtask

    // Random stream: every 16 accepted samples form a queued frame; frames run
    // one at a time, each followed by a single gap cycle
    task automatic test_backpressure(input int valid_pct, input int nframes, input int lat, input string name);
        logic [FW-1:0] fq_re[$], fq_im[$];
        logic [FW-1:0] bre, bim, cur_re, cur_im;
        logic signed [N-1:0] smp_re, smp_im;
        int  cnt, full_cnt, frames;
        bit  running, gap, begin_run, exp_ready;
        rst = 1'b1; s_valid = 1'b0;
        tick();
        rst = 1'b0;
        fft_lat = lat;
        cnt = 0; full_cnt = 0; frames = 0; running = 1'b0; gap = 1'b0;
        bre = '0; bim = '0; cur_re = '0; cur_im = '0;
        for (int c = 0; c < 3000 && frames < nframes; c++) begin
            s_valid = ($urandom_range(99) < valid_pct);
            s_re = N'($urandom); s_im = N'($urandom);
            smp_re = s_re; smp_im = s_im;
            tick();
            if (last_acc) begin
                bre[cnt*N +: N] = smp_re;
                bim[cnt*N +: N] = smp_im;
                cnt++;
                if (cnt == 16) begin
                    fq_re.push_back(bre); fq_im.push_back(bim);
                    cnt = 0; full_cnt++;
                end
            end
            begin_run = 1'b0;
            if (running) begin
                if (last_done) begin running = 1'b0; gap = 1'b1; frames++; end
            end else if (gap) begin
                gap = 1'b0;
                begin_run = (full_cnt > 0);
            end else begin
                begin_run = (full_cnt > 0);
            end
            if (begin_run) begin
                running = 1'b1; full_cnt--;
                cur_re = fq_re.pop_front(); cur_im = fq_im.pop_front();
            end
            exp_ready = (!running && !gap) || (PP && full_cnt == 0);
            checks++; if (fft_start !== running) $display("[TB] FAIL %s fft_start cyc %0d: got %b expected %b", name, c, fft_start, running); else passed++;
            checks++; if (frame_done !== gap) $display("[TB] FAIL %s frame_done cyc %0d: got %b expected %b", name, c, frame_done, gap); else passed++;
            checks++; if (s_ready !== exp_ready) $display("[TB] FAIL %s s_ready cyc %0d: got %b expected %b", name, c, s_ready, exp_ready); else passed++;
            checks++; if (frame_cnt !== 16'(frames)) $display("[TB] FAIL %s frame_cnt cyc %0d: got %0d expected %0d", name, c, frame_cnt, frames); else passed++;
            if (running || gap) begin
                checks++; if (frame_re !== cur_re) $display("[TB] FAIL %s frame_re cyc %0d: got %h expected %h", name, c, frame_re, cur_re); else passed++;
                checks++; if (frame_im !== cur_im) $display("[TB] FAIL %s frame_im cyc %0d: got %h expected %h", name, c, frame_im, cur_im); else passed++;
            end
        end
        checks++; if (frames !== nframes) $display("[TB] FAIL %s frame count timeout: got %0d expected %0d", name, frames, nframes); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_ramp();
        test_spurious_done();
        test_reset_mid_run();
        test_backpressure(100, 3, 40, "continuous");
        test_backpressure(60, 3, 25, "random_valid");
        test_backpressure(100, 4, 3, "short_fft");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
